// File: rtl/unlock_supervisor_pkg.sv
// Shared types and width helpers for the unlock supervisor.
package unlock_sup_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } sup_state_e;

    localparam int unsigned LEVEL_W = 2;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int unsigned width_for(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/unlock_supervisor_if.sv
// Event inputs from the unlocking system and supervisor status outputs.
interface unlock_supervisor_if
    import unlock_sup_pkg::*;
#(
    parameter int unsigned MAX_FAILS = 3
);
    localparam int unsigned FW = width_for(MAX_FAILS + 1);

    logic          unlock_i;
    logic          pwd_bad_i;
    logic          door_open;
    logic          lockout;
    logic          entry_en;
    logic [FW-1:0] fail_cnt;
    logic          alarm;

    modport master (
        output unlock_i, pwd_bad_i,
        input  door_open, lockout, entry_en, fail_cnt, alarm
    );

    modport slave (
        input  unlock_i, pwd_bad_i,
        output door_open, lockout, entry_en, fail_cnt, alarm
    );

endinterface

// File: rtl/unlock_supervisor_timer.sv
// Loadable down-counter that holds at zero; load wins over decrement.
module sup_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/unlock_supervisor.sv
// Door-release window, consecutive-failure counter and timed lockout.
// Define UNLOCK_SUP_ESCALATE_EN to double each successive lockout (up to 8x).
module unlock_supervisor
    import unlock_sup_pkg::*;
#(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned OPEN_CYCLES    = 100,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    unlock_supervisor_if.slave  bus
);

    localparam int unsigned FW = width_for(MAX_FAILS + 1);
`ifdef UNLOCK_SUP_ESCALATE_EN
    localparam int unsigned LOCK_MAX = LOCKOUT_CYCLES * 8;
`else
    localparam int unsigned LOCK_MAX = LOCKOUT_CYCLES;
`endif
    localparam int unsigned TW = width_for(max_u(OPEN_CYCLES, LOCK_MAX));

    sup_state_e    state_q, state_d;
    logic          door_q, door_d;
    logic          lock_q, lock_d;
    logic          entry_q, entry_d;
    logic [FW-1:0] fail_q, fail_d;
    logic          alarm_q, alarm_d;
    logic          unlock_q, bad_q;
    logic          primed_q;

    logic          ev_ok_c, ev_bad_c;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic [TW-1:0] lock_val;
    logic [TW-1:0] unused_tmr_cnt;
    logic          tmr_zero;

    // primed_q masks the first edge after reset so a level already high is not an event.
    assign ev_bad_c = primed_q & bus.pwd_bad_i & ~bad_q;
    assign ev_ok_c  = primed_q & bus.unlock_i & ~unlock_q & ~ev_bad_c;

`ifdef UNLOCK_SUP_ESCALATE_EN
    logic [LEVEL_W-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        if (ev_ok_c && (state_q != LOCKOUT)) begin
            level_d = '0;
        end else if (alarm_d && (level_q != '1)) begin
            level_d = level_q + LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign lock_val = TW'((LOCKOUT_CYCLES << level_q) - 1);
`else
    assign lock_val = TW'(LOCKOUT_CYCLES - 1);
`endif

    sup_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (state_q != IDLE),
        .cnt      (unused_tmr_cnt),
        .zero     (tmr_zero)
    );

    // Next-state and next-output logic; a bad password always beats an unlock.
    always_comb begin
        state_d  = state_q;
        door_d   = door_q;
        lock_d   = lock_q;
        fail_d   = fail_q;
        alarm_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE, OPEN: begin
                if (ev_bad_c) begin
                    door_d = 1'b0;
                    if (fail_q == FW'(MAX_FAILS - 1)) begin
                        state_d  = LOCKOUT;
                        lock_d   = 1'b1;
                        alarm_d  = 1'b1;
                        fail_d   = FW'(MAX_FAILS);
                        tmr_load = 1'b1;
                        tmr_val  = lock_val;
                    end else begin
                        state_d = IDLE;
                        if (fail_q < FW'(MAX_FAILS)) begin
                            fail_d = fail_q + FW'(1);
                        end
                    end
                end else if (ev_ok_c) begin
                    state_d  = OPEN;
                    door_d   = 1'b1;
                    fail_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(OPEN_CYCLES - 1);
                end else if ((state_q == OPEN) && tmr_zero) begin
                    state_d = IDLE;
                    door_d  = 1'b0;
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    lock_d  = 1'b0;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                door_d  = 1'b0;
                lock_d  = 1'b0;
            end
        endcase
        entry_d = ~lock_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            door_q   <= 1'b0;
            lock_q   <= 1'b0;
            entry_q  <= 1'b1;
            fail_q   <= '0;
            alarm_q  <= 1'b0;
            unlock_q <= 1'b0;
            bad_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            door_q   <= door_d;
            lock_q   <= lock_d;
            entry_q  <= entry_d;
            fail_q   <= fail_d;
            alarm_q  <= alarm_d;
            unlock_q <= bus.unlock_i;
            bad_q    <= bus.pwd_bad_i;
            primed_q <= 1'b1;
        end
    end

    assign bus.door_open = door_q;
    assign bus.lockout   = lock_q;
    assign bus.entry_en  = entry_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_unlock_supervisor.sv
// Directed bench: stimulus queues expected outputs per cycle, a monitor compares them.
module tb_unlock_supervisor;

    typedef struct {
        int    cyc;
        string nm;
        int    sig;
        int    val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sq[$];
    event chk_ev;
    string sig_nm[5] = '{"door_open", "lockout", "entry_en", "fail_cnt", "alarm"};

    unlock_supervisor_if #(.MAX_FAILS(3)) bus ();

    unlock_supervisor #(
        .MAX_FAILS      (3),
        .OPEN_CYCLES    (4),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_sig(input int id);
        case (id)
            0:       return int'(bus.door_open);
            1:       return int'(bus.lockout);
            2:       return int'(bus.entry_en);
            3:       return int'(bus.fail_cnt);
            default: return int'(bus.alarm);
        endcase
    endfunction

    task automatic exp1(input int c, input string nm, input int sig, input int val);
        exp_t e;
        e.cyc = c;
        e.nm  = nm;
        e.sig = sig;
        e.val = val;
        sq.push_back(e);
    endtask

    task automatic exp_all(input int c, input string nm, input int door, input int lk,
                           input int fail, input int alarm);
        exp1(c, nm, 0, door);
        exp1(c, nm, 1, lk);
        exp1(c, nm, 2, (lk != 0) ? 0 : 1);
        exp1(c, nm, 3, fail);
        exp1(c, nm, 4, alarm);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_ok(input int t);
        run_to(t);
        bus.unlock_i = 1'b1;
        run_to(t + 1);
        bus.unlock_i = 1'b0;
    endtask

    task automatic pulse_bad(input int t);
        run_to(t);
        bus.pwd_bad_i = 1'b1;
        run_to(t + 1);
        bus.pwd_bad_i = 1'b0;
    endtask

    // Monitor: compare every queued expectation that is due at this sample point.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk or chk_ev);
            #1;
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                e   = sq.pop_front();
                act = get_sig(e.sig);
                total++;
                if (e.cyc != cyc || act != e.val) begin
                    bad++;
                    $display("FAIL %s.%s cyc=%0d due=%0d: got %0d want %0d",
                             e.nm, sig_nm[e.sig], cyc, e.cyc, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int c;
        int b;
        int len;
        rst_n         = 1'b0;
        bus.unlock_i  = 1'b1;
        bus.pwd_bad_i = 1'b1;

        // Reset held with inputs high; release must not create events.
        @(negedge clk);
        total++;
        if (bus.door_open !== 1'b0 || bus.entry_en !== 1'b1 || bus.fail_cnt !== 2'd0) begin
            bad++;
            $display("FAIL direct rst_hold: door=%0b entry=%0b fail=%0d",
                     bus.door_open, bus.entry_en, bus.fail_cnt);
        end
        exp_all(2, "rst_hold", 0, 0, 0, 0);
        run_to(3);
        rst_n = 1'b1;
        exp_all(4, "rst_rel", 0, 0, 0, 0);
        exp_all(6, "rst_rel_hold", 0, 0, 0, 0);
        run_to(6);
        bus.unlock_i  = 1'b0;
        bus.pwd_bad_i = 1'b0;
        exp_all(8, "rst_idle", 0, 0, 0, 0);
        run_to(9);

        // Unlock window of 4 cycles.
        c = 10;
        run_to(c);
        exp_all(c + 1, "open_first", 1, 0, 0, 0);
        exp1(c + 2, "open_mid", 0, 1);
        exp1(c + 4, "open_last", 0, 1);
        exp_all(c + 5, "open_end", 0, 0, 0, 0);
        pulse_ok(c);
        run_to(c + 6);
        total++;
        if (bus.door_open !== 1'b0 || bus.fail_cnt !== 2'd0) begin
            bad++;
            $display("FAIL direct open_closed: door=%0b fail=%0d", bus.door_open, bus.fail_cnt);
        end

        // Three failures, lockout for 8 cycles.
        c = 20;
        run_to(c);
        exp_all(c + 1,  "bad1",      0, 0, 1, 0);
        exp_all(c + 3,  "bad2",      0, 0, 2, 0);
        exp_all(c + 4,  "pre_lock",  0, 0, 2, 0);
        exp_all(c + 5,  "lock_in",   0, 1, 3, 1);
        exp_all(c + 6,  "lock_hold", 0, 1, 3, 0);
        exp_all(c + 12, "lock_last", 0, 1, 3, 0);
        exp_all(c + 13, "lock_exit", 0, 0, 0, 0);
        pulse_bad(c);
        pulse_bad(c + 2);
        pulse_bad(c + 4);
        total++;
        if (bus.lockout !== 1'b1 || bus.entry_en !== 1'b0 || bus.fail_cnt !== 2'd3) begin
            bad++;
            $display("FAIL direct lock_in: lockout=%0b entry=%0b fail=%0d",
                     bus.lockout, bus.entry_en, bus.fail_cnt);
        end
        run_to(c + 14);

        // Unlock between lockouts.
        c = 40;
        run_to(c);
        exp_all(c + 1, "reopen", 1, 0, 0, 0);
        exp_all(c + 5, "reopen_end", 0, 0, 0, 0);
        pulse_ok(c);
        run_to(c + 6);

        // Events during lockout are ignored; held pwd_bad across exit is not recounted.
        c = 50;
        run_to(c);
        exp_all(c + 5,  "lk2_in",       0, 1, 3, 1);
        exp_all(c + 8,  "lk2_unlock",   0, 1, 3, 0);
        exp_all(c + 9,  "lk2_unlock2",  0, 1, 3, 0);
        exp_all(c + 11, "lk2_held",     0, 1, 3, 0);
        exp_all(c + 12, "lk2_last",     0, 1, 3, 0);
        exp_all(c + 13, "lk2_exit",     0, 0, 0, 0);
        exp_all(c + 14, "lk2_held_out", 0, 0, 0, 0);
        exp_all(c + 16, "lk2_held_end", 0, 0, 0, 0);
        pulse_bad(c);
        pulse_bad(c + 2);
        pulse_bad(c + 4);
        pulse_ok(c + 7);
        run_to(c + 10);
        bus.pwd_bad_i = 1'b1;
        run_to(c + 16);
        bus.pwd_bad_i = 1'b0;
        run_to(c + 18);

        // Simultaneous edges count as a failure only.
        c = 70;
        run_to(c);
        exp_all(c + 1, "simul", 0, 0, 1, 0);
        exp_all(c + 3, "simul_hold", 0, 0, 1, 0);
        bus.unlock_i  = 1'b1;
        bus.pwd_bad_i = 1'b1;
        run_to(c + 1);
        bus.unlock_i  = 1'b0;
        bus.pwd_bad_i = 1'b0;
        run_to(c + 4);

        // Bad password during the open window closes the door at once.
        c = 80;
        run_to(c);
        exp_all(c + 1, "open2",      1, 0, 0, 0);
        exp_all(c + 2, "open2_mid",  1, 0, 0, 0);
        exp_all(c + 3, "abort",      0, 0, 1, 0);
        exp_all(c + 6, "abort_stay", 0, 0, 1, 0);
        pulse_ok(c);
        pulse_bad(c + 2);
        run_to(c + 7);

        // Asynchronous reset in the middle of a lockout.
        c = 90;
        run_to(c);
        exp_all(c + 1, "pre_rst_bad", 0, 0, 2, 0);
        exp_all(c + 3, "pre_rst_lock", 0, 1, 3, 1);
        pulse_bad(c);
        pulse_bad(c + 2);
        run_to(c + 6);
        #2;
        rst_n = 1'b0;
        exp_all(c + 6, "async_rst", 0, 0, 0, 0);
        ->chk_ev;
        #1;
        total++;
        if (bus.lockout !== 1'b0 || bus.entry_en !== 1'b1 || bus.fail_cnt !== 2'd0) begin
            bad++;
            $display("FAIL direct async_rst: lockout=%0b entry=%0b fail=%0d",
                     bus.lockout, bus.entry_en, bus.fail_cnt);
        end
        run_to(c + 7);
        rst_n = 1'b1;
        exp_all(c + 9, "post_rst", 0, 0, 0, 0);
        run_to(c + 10);

`ifdef UNLOCK_SUP_ESCALATE_EN
        // Back-to-back lockouts without an unlock: 8, 16, 32 cycles.
        b = 110;
        for (int k = 0; k < 3; k++) begin
            len = 8 << k;
            run_to(b);
            exp_all(b + 5,       "esc_in",   0, 1, 3, 1);
            exp_all(b + 4 + len, "esc_last", 0, 1, 3, 0);
            exp_all(b + 5 + len, "esc_exit", 0, 0, 0, 0);
            pulse_bad(b);
            pulse_bad(b + 2);
            pulse_bad(b + 4);
            run_to(b + 6 + len);
            b = b + 6 + len;
        end
`else
        b   = 0;
        len = 0;
`endif

        run_to(cyc + 3);
        while (sq.size() > 0) begin
            exp_t e;
            e = sq.pop_front();
            total++;
            bad++;
            $display("FAIL %s.%s never checked (due cyc %0d, want %0d)",
                     e.nm, sig_nm[e.sig], e.cyc, e.val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
